branch_redirect_ctrl: RTL

Sequencer that turns a resolved taken branch in EX into a clean front-end redirect. It sits between the EX branch-resolution logic and the IF/ID stages. It latches the branch target and holds a redirect request until fetch accepts it. It kills wrong-path instructions in IF, ID and EX, and drains wrong-path fetches still in flight in instruction memory.

---
 rtl/branch_ctrl_pkg.sv | 6 +
 rtl/branch_stat_cnt.sv | 13 +
 rtl/branch_redirect_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/branch_ctrl_pkg.sv
// branch_ctrl_pkg: state encoding and shared widths for the branch redirect controller.
package branch_ctrl_pkg;
   localparam int WORD_DEF = 32;
   localparam int DCNT_W   = 3;
   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DRAIN = 2'd2} state_t;
endpackage

// File: rtl/branch_stat_cnt.sv
// branch_stat_cnt: enabled wrap-around event counter.
module branch_stat_cnt #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         i_en,
   output logic [W-1:0] o_cnt
);
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) o_cnt <= '0;
      else if (i_en) o_cnt <= o_cnt + W'(1);
endmodule

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: turns a taken EX branch into a held redirect plus wrong-path flushes.
// Define BRANCH_STAT_EN to add the branch/taken/wait statistics counters.
import branch_ctrl_pkg::*;

module branch_redirect_ctrl #(
   parameter int WORD = WORD_DEF,
`ifdef BRANCH_STAT_EN
   parameter int CNT_W = 32,
`endif
   parameter int IMEM_LAT = 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             ex_valid,
   input  logic             ex_is_branch,
   input  logic             ex_taken,
   input  logic [WORD-1:0]  ex_target,
   input  logic             fetch_ready,
`ifdef BRANCH_STAT_EN
   output logic [CNT_W-1:0] stat_branch,
   output logic [CNT_W-1:0] stat_taken,
   output logic [CNT_W-1:0] stat_wait,
`endif
   output logic             redirect_valid,
   output logic [WORD-1:0]  redirect_pc,
   output logic             flush_if,
   output logic             flush_id,
   output logic             flush_ex,
   output logic             busy
);
   state_t            r_state, w_next;
   logic [DCNT_W-1:0] r_dcnt, w_dcnt;
   logic              w_trig, w_accept, w_done;

   assign w_trig   = ex_valid & ex_is_branch & ex_taken;
   assign w_accept = (r_state == IDLE) & w_trig;
   assign w_done   = redirect_valid & fetch_ready;

   always_comb begin
      w_next = r_state;
      w_dcnt = r_dcnt;
      case (r_state)
         IDLE: w_next = w_trig ? REQ : IDLE;
         REQ: if (w_done) begin
            w_next = (IMEM_LAT == 0) ? IDLE : DRAIN;
            w_dcnt = (IMEM_LAT == 0) ? '0 : DCNT_W'(IMEM_LAT - 1);
         end
         DRAIN: begin
            w_next = (r_dcnt == '0) ? IDLE : DRAIN;
            w_dcnt = (r_dcnt == '0) ? '0 : r_dcnt - DCNT_W'(1);
         end
         default: w_next = IDLE;
      endcase
   end

   // Outputs are registered from the next state so no ex_* input reaches a port combinationally.
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         r_state        <= IDLE;
         r_dcnt         <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         flush_if       <= 1'b0;
         flush_id       <= 1'b0;
         flush_ex       <= 1'b0;
         busy           <= 1'b0;
      end else begin
         r_state        <= w_next;
         r_dcnt         <= w_dcnt;
         redirect_valid <= w_next == REQ;
         flush_if       <= w_next != IDLE;
         flush_id       <= w_next == REQ;
         flush_ex       <= w_accept;
         busy           <= w_next != IDLE;
         if (w_accept) redirect_pc <= ex_target;
      end

   always @(posedge clk)
      if (rstn) assert (!((r_state != IDLE) && w_trig))
         else $warning("branch_redirect_ctrl: taken branch while busy was dropped");

`ifdef BRANCH_STAT_EN
   branch_stat_cnt #(.W(CNT_W)) u_stat_branch (
      .clk(clk), .rstn(rstn), .i_en((r_state == IDLE) & ex_valid & ex_is_branch), .o_cnt(stat_branch));
   branch_stat_cnt #(.W(CNT_W)) u_stat_taken (
      .clk(clk), .rstn(rstn), .i_en(w_accept), .o_cnt(stat_taken));
   branch_stat_cnt #(.W(CNT_W)) u_stat_wait (
      .clk(clk), .rstn(rstn), .i_en((r_state == REQ) & ~fetch_ready), .o_cnt(stat_wait));
`endif
endmodule
